// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared core types for the fetch stage.
// Holds the NOP encoding, the fetch FSM states and the instruction-buffer entry.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry instruction buffer with wrap-around pointers.
// A flush empties it at the next edge; push on a full buffer is taken only alongside a pop.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ENTRY_W-1:0]           wdata,
    output logic [ENTRY_W-1:0]           rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic do_push;
    logic do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with request throttling, redirect flush
// and a small instruction buffer feeding decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_next;
    fetch_entry_t  head;
    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_next;
    logic [CW-1:0] count;
    logic [CW:0]   inflight;
    logic          fire;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign target    = {redirect_pc[31:2], 2'b00};
    assign inflight  = {1'b0, outstanding} + {1'b0, count};
    assign imem_req  = state != ST_RESET && !redirect && inflight < (CW+1)'(DEPTH);
    assign imem_addr = pc;
    assign fire      = imem_req && imem_gnt;
    // Responses are only meaningful once RUN is reached and something is in flight.
    assign accept    = imem_rvalid && state != ST_RESET && outstanding != '0;
    assign push      = accept && discard == '0 && !redirect && (!full || pop);
    assign pop       = if_valid && if_ready && !redirect;

    assign outstanding_next = outstanding + CW'(fire) - CW'(accept);
    // Every request still in flight after a redirect belongs to the old path.
    assign discard_next = redirect ? outstanding_next : discard - CW'(accept && discard != '0);

    always_comb begin
        state_next = ST_RUN;
        if (discard_next != '0)
            state_next = ST_FLUSH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_RESET;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            pc          <= redirect ? target : fire ? pc + 32'd4 : pc;
            rsp_pc      <= redirect ? target : push ? rsp_pc + 32'd4 : rsp_pc;
            outstanding <= outstanding_next;
            discard     <= discard_next;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata ({rsp_pc, imem_rdata}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign if_valid = !empty;
    assign if_pc    = empty ? 32'h0 : head.pc;
    assign if_instr = empty ? NOP_INSTR : head.instr;

    assert property (@(posedge clk) disable iff (!rst)
        !(imem_rvalid && state != ST_RESET && outstanding == '0))
        else $error("fetch_unit: rvalid with nothing outstanding");

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic checked cycle by cycle against a queue-based
// model in which in-flight requests carry a path epoch and redirects bump the epoch.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 0, rst = 1, redirect = 0, imem_gnt = 0, imem_rvalid = 0, if_ready = 0;
    logic [31:0] redirect_pc = 0, imem_rdata = 0;
    logic imem_req, if_valid;
    logic [31:0] imem_addr, if_pc, if_instr;
    logic [97:0] act, exp_v;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;
    assign act = {imem_req, imem_addr, if_valid, if_pc, if_instr};

    typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    req_t pend[$];
    ent_t buffer[$];
    logic [31:0] m_pc;
    int epoch, cyc, last_due, lat_lo = 1, lat_hi = 1;
    int tests, fails;
    bit m_first, rsp_now, exp_req, exp_valid;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0001;
    endfunction

    task automatic drive(input bit rd, input logic [31:0] rpc, input bit gnt, input bit rdy, input bit junk);
        logic [31:0] hpc, hin;
        @(negedge clk);
        redirect = rd; redirect_pc = rpc; imem_gnt = gnt; if_ready = rdy;
        rsp_now = pend.size() > 0 ? pend[0].due <= cyc : 1'b0;
        imem_rvalid = rsp_now || junk;
        imem_rdata = rsp_now ? mem_data(pend[0].addr) : $urandom;
        #1;
        exp_req = !m_first && !rd && (pend.size() + buffer.size() < DEPTH);
        exp_valid = buffer.size() > 0;
        hpc = exp_valid ? buffer[0].pc : 32'h0;
        hin = exp_valid ? buffer[0].instr : 32'h0000_0013;
        exp_v = {exp_req, m_pc, exp_valid, hpc, hin};
    endtask

    task automatic advance();
        bit fire;
        fire = exp_req && imem_gnt;
        if (if_ready && exp_valid && !redirect) void'(buffer.pop_front());
        if (rsp_now) begin
            req_t r;
            r = pend.pop_front();
            if (r.epoch == epoch && !redirect) buffer.push_back('{r.addr, mem_data(r.addr)});
        end
        if (fire) begin
            int lat;
            lat = $urandom_range(lat_hi, lat_lo);
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            pend.push_back('{m_pc, last_due, epoch});
            m_pc += 4;
        end
        if (redirect) begin
            buffer.delete();
            epoch++;
            m_pc = redirect_pc & ~32'h3;
        end
        m_first = 0;
        cyc++;
        @(posedge clk);
    endtask

    task automatic test_reset(input string tag);
        @(negedge clk);
        #2 rst = 0;
        imem_rvalid = 1; imem_rdata = $urandom; imem_gnt = 1; if_ready = 1; redirect = 0;
        pend.delete(); buffer.delete(); m_pc = 32'h0; m_first = 1; last_due = cyc;
        #1 tests++;
        if ({imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b0, 32'h0, NOP_INSTR}) begin
            fails++; $display("FAIL %s_immediate: got %h", tag, act);
        end
        repeat (2) @(posedge clk);
        #1 tests++;
        if (act !== {1'b0, 32'h0, 1'b0, 32'h0, NOP_INSTR}) begin
            fails++; $display("FAIL %s_held: got %h", tag, act);
        end
        #1 rst = 1;
        drive(0, 0, 1, 1, 1);
        tests++;
        if (act !== exp_v) begin fails++; $display("FAIL %s_first_cycle: got %h want %h", tag, act, exp_v); end
        advance();
    endtask

    task automatic test_sequential();
        int first;
        bit seen;
        first = -1; seen = 0; lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 1, 1, 0);
            tests++;
            if (act !== exp_v) begin fails++; $display("FAIL seq c%0d: got %h want %h", i, act, exp_v); end
            if (first >= 0 && i == first + 1) begin
                tests++;
                if (imem_addr !== 32'h4) begin fails++; $display("FAIL seq_second_addr: got %h want 4", imem_addr); end
            end
            if (first >= 0 && i == first + 2) begin
                seen = 1; tests++;
                if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, mem_data(32'h0)}) begin
                    fails++; $display("FAIL seq_first_if: got %b %h %h want 1 0 %h", if_valid, if_pc, if_instr, mem_data(32'h0));
                end
            end
            if (first < 0 && exp_req) first = i;
            advance();
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL seq_no_grant: got none want grant"); end
    endtask

    task automatic test_backpressure();
        logic [31:0] prev;
        bit have;
        have = 0; prev = 0; lat_lo = 1; lat_hi = 2;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0);
            tests++;
            if (act !== exp_v) begin fails++; $display("FAIL bp_stall c%0d: got %h want %h", i, act, exp_v); end
            if (i == 4) begin
                tests++;
                if ({imem_req, if_valid} !== 2'b01) begin fails++; $display("FAIL bp_throttle: got req=%b v=%b want 0 1", imem_req, if_valid); end
            end
            advance();
        end
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, 1, 1, 0);
            tests++;
            if (act !== exp_v) begin fails++; $display("FAIL bp_run c%0d: got %h want %h", i, act, exp_v); end
            if (if_valid) begin
                if (have) begin
                    tests++;
                    if (if_pc !== prev + 32'd4) begin fails++; $display("FAIL bp_order: got %h want %h", if_pc, prev + 32'd4); end
                end
                prev = if_pc; have = 1;
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        int n;
        bit got;
        n = 0; got = 0; lat_lo = 3; lat_hi = 3;
        while (pend.size() < 2 && n < 20) begin
            drive(0, 0, 1, 1, 0);
            tests++;
            if (act !== exp_v) begin fails++; $display("FAIL redir_setup c%0d: got %h want %h", n, act, exp_v); end
            advance(); n++;
        end
        drive(1, 32'h0000_0102, 1, 1, 0);
        tests++;
        if (act !== exp_v || pend.size() != 2) begin fails++; $display("FAIL redir_cycle: got %h want %h inflight %0d", act, exp_v, pend.size()); end
        advance();
        drive(0, 0, 1, 1, 0);
        tests++;
        if (imem_addr !== 32'h100) begin fails++; $display("FAIL redir_addr: got %h want 100", imem_addr); end
        for (int i = 0; i < 20 && !got; i++) begin
            if (i > 0) drive(0, 0, 1, 1, 0);
            tests++;
            if (act !== exp_v) begin fails++; $display("FAIL redir_wait c%0d: got %h want %h", i, act, exp_v); end
            if (if_valid) begin
                got = 1; tests++;
                if (if_pc !== 32'h100) begin fails++; $display("FAIL redir_first_pc: got %h want 100", if_pc); end
            end
            advance();
        end
        tests++;
        if (!got) begin fails++; $display("FAIL redir_timeout: got no if_valid want one"); end
    endtask

    task automatic test_collide();
        int n;
        bit got;
        n = 0; got = 0; lat_lo = 2; lat_hi = 2;
        while (!(pend.size() >= 2 && pend[0].due <= cyc) && n < 40) begin
            drive(0, 0, 1, 1, 0);
            tests++;
            if (act !== exp_v) begin fails++; $display("FAIL coll_setup c%0d: got %h want %h", n, act, exp_v); end
            advance(); n++;
        end
        drive(1, 32'h0000_0A00, 1, 1, 0);
        tests++;
        if (act !== exp_v || !imem_rvalid || imem_req !== 1'b0) begin
            fails++; $display("FAIL coll_cycle: got %h rvalid=%b want %h rvalid=1", act, imem_rvalid, exp_v);
        end
        advance();
        for (int i = 0; i < 20 && !got; i++) begin
            drive(0, 0, 1, 1, 0);
            tests++;
            if (act !== exp_v) begin fails++; $display("FAIL coll_wait c%0d: got %h want %h", i, act, exp_v); end
            if (if_valid) begin
                got = 1; tests++;
                if (if_pc !== 32'hA00) begin fails++; $display("FAIL coll_stale: got %h want a00", if_pc); end
            end
            advance();
        end
        tests++;
        if (!got) begin fails++; $display("FAIL coll_timeout: got no if_valid want one"); end
    endtask

    task automatic test_wrap();
        bit next_chk, done;
        next_chk = 0; done = 0; lat_lo = 1; lat_hi = 2;
        drive(1, 32'hFFFF_FFFF, 1, 1, 0);
        tests++;
        if (act !== exp_v) begin fails++; $display("FAIL wrap_redir: got %h want %h", act, exp_v); end
        advance();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 1, 0);
            tests++;
            if (act !== exp_v) begin fails++; $display("FAIL wrap c%0d: got %h want %h", i, act, exp_v); end
            if (next_chk) begin
                next_chk = 0; done = 1; tests++;
                if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
            end
            if (exp_req && m_pc == 32'hFFFF_FFFC) next_chk = 1;
            advance();
        end
        tests++;
        if (!done) begin fails++; $display("FAIL wrap_timeout: got no grant want one"); end
    endtask

    task automatic test_random(input int cycles);
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < cycles; i++) begin
            drive($urandom_range(15, 0) == 0, $urandom, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, 0);
            tests++;
            if (act !== exp_v) begin fails++; $display("FAIL rand c%0d: got %h want %h", i, act, exp_v); end
            advance();
        end
    endtask

    task automatic test_reset_midburst();
        int n;
        n = 0; lat_lo = 3; lat_hi = 3;
        while (pend.size() == 0 && n < 20) begin
            drive(0, 0, 1, 1, 0);
            tests++;
            if (act !== exp_v) begin fails++; $display("FAIL mid_setup c%0d: got %h want %h", n, act, exp_v); end
            advance(); n++;
        end
        test_reset("midburst");
        test_random(60);
    endtask

    initial begin
        tests = 0; fails = 0; epoch = 0; cyc = 0; last_due = 0; m_first = 1; m_pc = 0;
        test_reset("reset");
        test_sequential();
        test_backpressure();
        test_redirect();
        test_collide();
        test_wrap();
        test_random(400);
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
